// File: rtl/shift_sequencer_pkg.sv
// Shared widths, state encoding and select helper for the multi-pass rotate sequencer.
package shift_sequencer_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned AMT_W  = 3;
  localparam int unsigned PASS_W = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // One-hot of the highest set bit; zero input gives zero.
  function automatic logic [AMT_W-1:0] msb_onehot(input logic [AMT_W-1:0] v);
    logic [AMT_W-1:0] r;
    r = '0;
    for (int i = 0; i < int'(AMT_W); i++) begin
      if (v[i]) r = AMT_W'(1) << i;
    end
    return r;
  endfunction

endpackage

// File: rtl/shifter.sv
// Single-pass 8-bit rotator: rotates by the weight of the highest set bit of shift.
module shifter
  import shift_sequencer_pkg::*;
(
  input  logic [DATA_W-1:0] in,
  input  logic              direction,
  input  logic [AMT_W-1:0]  shift,
  output logic [DATA_W-1:0] out
);

  logic [AMT_W-1:0]    n;
  logic [2*DATA_W-1:0] dbl;

  always_comb begin
    n = '0;
    if (shift[2])      n = AMT_W'(4);
    else if (shift[1]) n = AMT_W'(2);
    else if (shift[0]) n = AMT_W'(1);
    dbl = {in, in};
    // direction 1 = rotate right, 0 = rotate left
    if (direction) out = DATA_W'(dbl >> n);
    else           out = DATA_W'((dbl << n) >> DATA_W);
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-pass rotate controller: one shifter pass per set amount bit, highest first,
// with valid/ready handshakes on request and result.
module shift_sequencer
  import shift_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_dir,
  input  logic [AMT_W-1:0]  in_amt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [PASS_W-1:0] out_passes,
  output logic              busy
);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                dir_q, dir_d;
  logic [AMT_W-1:0]    rem_q, rem_d;
  logic [PASS_W-1:0]   passes_q, passes_d;
  logic [AMT_W-1:0]    sel_c;
  logic [DATA_W-1:0]   shift_out;

  assign sel_c = msb_onehot(rem_q);

  shifter u_shifter (
    .in        (data_q),
    .direction (dir_q),
    .shift     (sel_c),
    .out       (shift_out)
  );

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    dir_d    = dir_q;
    rem_d    = rem_q;
    passes_d = passes_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          data_d   = in_data;
          dir_d    = in_dir;
          rem_d    = in_amt;
          passes_d = '0;
          state_d  = (in_amt != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        data_d   = shift_out;
        rem_d    = rem_q & ~sel_c;
        passes_d = passes_q + PASS_W'(1);
        if (rem_d == '0) state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, datapath and decoded handshake flags, all registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      data_q    <= '0;
      dir_q     <= 1'b0;
      rem_q     <= '0;
      passes_q  <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      dir_q     <= dir_d;
      rem_q     <= rem_d;
      passes_q  <= passes_d;
      in_ready  <= (state_d == S_IDLE);
      out_valid <= (state_d == S_DONE);
      busy      <= (state_d == S_RUN) || (state_d == S_DONE);
    end
  end

  assign out_data   = data_q;
  assign out_passes = passes_q;

endmodule
